// File: rtl/wallet_rng_pkg.sv
// Shared types and constants for the wallet RNG entropy collector.
// Contents: collector state enum, LFSR mask/seed, word width, one-step
// Galois LFSR helper used by the top level.
package wallet_rng_pkg;

    localparam int unsigned RNG_WORD_W        = 32;
    localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2,
        FAULT   = 2'd3
    } rng_state_t;

    // One right-shifting Galois step; the mask is folded in when the LSB drops out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/wallet_rng_health.sv
// Raw noise front end: 2-flop synchronizer plus repetition-count health test.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   i_raw_bit     asynchronous noise bit
//   i_tick        a sample is being taken this cycle
//   o_sample      synchronized noise bit (the value sampled on i_tick)
//   o_fail_c      combinational: this sample brings the run length to REP_LIMIT
module wallet_rng_health #(
    parameter int unsigned REP_LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw_bit,
    input  logic i_tick,
    output logic o_sample,
    output logic o_fail_c
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [7:0] r_run;
    logic [7:0] w_run_next;

    // Run length after this sample; saturates so a stuck source cannot wrap.
    always_comb begin
        w_run_next = 8'd1;
        if (r_sync2 == r_prev) begin
            w_run_next = (r_run == 8'hFF) ? r_run : (r_run + 8'd1);
        end
    end

    assign o_fail_c = i_tick && (w_run_next >= 8'(REP_LIMIT));
    assign o_sample = r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_run   <= 8'd0;
        end else begin
            r_sync1 <= i_raw_bit;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_prev <= r_sync2;
                r_run  <= w_run_next;
            end
        end
    end

endmodule

// File: rtl/wallet_rng_source.sv
// Entropy collector feeding the 32-bit random-number PIO input port.
// Samples a raw noise bit, debiases it with a von Neumann extractor,
// health-checks it, packs 32 accepted bits and optionally whitens the word.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   raw_bit       asynchronous noise bit
//   enable        collection enable (level)
//   ack           software acknowledge; a rising edge consumes the word
//   rnd_word      conditioned word for the PIO in_port
//   rnd_valid     rnd_word holds an unread word
//   health_fail   sticky repetition-test fault
//   fill_count    accepted bits currently in the accumulator
module wallet_rng_source
    import wallet_rng_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned REP_LIMIT  = 16,
    parameter int unsigned WHITEN     = 1,
    parameter logic [31:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_bit,
    input  logic             enable,
    input  logic             ack,
    output logic [WIDTH-1:0] rnd_word,
    output logic             rnd_valid,
    output logic             health_fail,
    output logic [5:0]       fill_count
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    rng_state_t       r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_pair_phase;
    logic             r_pair_first;
    logic [31:0]      r_acc;
    logic [31:0]      r_lfsr;
    logic [5:0]       r_fill;
    logic [31:0]      r_word;
    logic             r_valid;
    logic             r_health;
    logic             r_ack_q;

    logic             w_tick;
    logic             w_sample;
    logic             w_fail;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_ack_rise;
    logic [31:0]      w_acc_next;
    logic [31:0]      w_lfsr_next;

    // Sampling only advances while actively collecting with enable still high.
    assign w_tick      = (r_state == COLLECT) && enable &&
                         (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
    // Second sample of a pair that differs from the first: 10 -> 1, 01 -> 0.
    assign w_accept    = w_tick && r_pair_phase && (r_pair_first != w_sample);
    assign w_last_bit  = w_accept && (r_fill == 6'(RNG_WORD_W - 1));
    assign w_acc_next  = {r_acc[30:0], r_pair_first};
    assign w_lfsr_next = lfsr_step(r_lfsr);
    assign w_ack_rise  = ack & ~r_ack_q;

    wallet_rng_health #(
        .REP_LIMIT (REP_LIMIT)
    ) u_health (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_raw_bit (raw_bit),
        .i_tick    (w_tick),
        .o_sample  (w_sample),
        .o_fail_c  (w_fail)
    );

    // Collector FSM with datapath; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_pair_phase <= 1'b0;
            r_pair_first <= 1'b0;
            r_acc        <= 32'h0;
            r_lfsr       <= LFSR_SEED;
            r_fill       <= 6'd0;
            r_word       <= 32'h0;
            r_valid      <= 1'b0;
            r_health     <= 1'b0;
            r_ack_q      <= 1'b0;
        end else begin
            r_ack_q <= ack;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (!enable) begin
                        r_state      <= IDLE;
                        r_acc        <= 32'h0;
                        r_fill       <= 6'd0;
                        r_div_cnt    <= '0;
                        r_pair_phase <= 1'b0;
                    end else if (w_fail) begin
                        // Fault beats a simultaneous 32nd bit: nothing is published.
                        r_state      <= FAULT;
                        r_health     <= 1'b1;
                        r_word       <= 32'h0;
                        r_valid      <= 1'b0;
                        r_acc        <= 32'h0;
                        r_fill       <= 6'd0;
                        r_div_cnt    <= '0;
                        r_pair_phase <= 1'b0;
                    end else begin
                        r_div_cnt <= w_tick ? '0 : (r_div_cnt + DIV_W'(1));
                        if (w_tick) begin
                            r_pair_phase <= ~r_pair_phase;
                            if (!r_pair_phase) begin
                                r_pair_first <= w_sample;
                            end
                        end
                        if (w_accept) begin
                            r_lfsr <= w_lfsr_next;
                            if (w_last_bit) begin
                                r_state      <= READY;
                                r_word       <= (WHITEN != 0) ? (w_acc_next ^ w_lfsr_next)
                                                              : w_acc_next;
                                r_valid      <= 1'b1;
                                r_acc        <= 32'h0;
                                r_fill       <= 6'd0;
                                r_div_cnt    <= '0;
                                r_pair_phase <= 1'b0;
                            end else begin
                                r_acc  <= w_acc_next;
                                r_fill <= r_fill + 6'd1;
                            end
                        end
                    end
                end

                READY: begin
                    // Either a consume or a disable retires the word.
                    if (w_ack_rise || !enable) begin
                        r_word  <= 32'h0;
                        r_valid <= 1'b0;
                        r_state <= enable ? COLLECT : IDLE;
                    end
                end

                FAULT: begin
                    r_health <= 1'b1;
                    r_word   <= 32'h0;
                    r_valid  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rnd_word    = WIDTH'(r_word);
    assign rnd_valid   = r_valid;
    assign health_fail = r_health;
    assign fill_count  = r_fill;

endmodule

// File: tb/tb_wallet_rng_source.sv
module tb_wallet_rng_source;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        raw_bit;
    logic        enable;
    logic        ack;

    logic [31:0] word0, wordw, wordd;
    logic        valid0, validw, validd;
    logic        hf0, hfw, hfd;
    logic [5:0]  fill0, fillw, filld;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Raw debiased word, one sample per clock.
    wallet_rng_source #(.WIDTH(32), .SAMPLE_DIV(1), .REP_LIMIT(16), .WHITEN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .raw_bit(raw_bit), .enable(enable), .ack(ack),
        .rnd_word(word0), .rnd_valid(valid0), .health_fail(hf0), .fill_count(fill0));

    // Whitened word, one sample per clock.
    wallet_rng_source #(.WIDTH(32), .SAMPLE_DIV(1), .REP_LIMIT(16), .WHITEN(1)) dutw (
        .clk(clk), .reset_n(reset_n), .raw_bit(raw_bit), .enable(enable), .ack(ack),
        .rnd_word(wordw), .rnd_valid(validw), .health_fail(hfw), .fill_count(fillw));

    // One sample every third clock.
    wallet_rng_source #(.WIDTH(32), .SAMPLE_DIV(3), .REP_LIMIT(16), .WHITEN(0)) dutd (
        .clk(clk), .reset_n(reset_n), .raw_bit(raw_bit), .enable(enable), .ack(ack),
        .rnd_word(wordd), .rnd_valid(validd), .health_fail(hfd), .fill_count(filld));

    typedef struct {
        logic [3:0]  pat;
        logic [31:0] exp_word;
        int          exp_edges;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_n(input int n);
        logic [31:0] s;
        s = 32'hACE1_2468;
        for (int i = 0; i < n; i++) begin
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
        return s;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        ack     = 1'b0;
        raw_bit = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives a repeating 4-sample pattern (MSB first) and raises enable so the
    // first sample taken is pat[3]. Returns posedges counted from the enable edge
    // until dut0 shows a word or fill0 reaches stop_fill.
    task automatic collect(input logic [3:0] pat, input int stop_fill, output int edges);
        int k;
        edges = 0;
        @(negedge clk); raw_bit = pat[3];
        @(negedge clk); raw_bit = pat[2]; enable = 1'b1;
        k = 2;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (valid0 || (int'(fill0) == stop_fill)) break;
            raw_bit = pat[3 - (k % 4)];
            k++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        int          e0, ed;
        logic [31:0] saved_w;
        logic        w_changed;

        vecs[0] = '{4'b1010, 32'hFFFF_FFFF, 65};
        vecs[1] = '{4'b0101, 32'h0000_0000, 65};
        vecs[2] = '{4'b1001, 32'hAAAA_AAAA, 65};
        vecs[3] = '{4'b1101, 32'h0000_0000, 129};

        do_reset();
        chk("reset_word0",  word0,  32'h0);
        chk("reset_valid0", 32'(valid0), 32'h0);
        chk("reset_hf0",    32'(hf0), 32'h0);
        chk("reset_fill0",  32'(fill0), 32'h0);
        chk("reset_wordw",  wordw,  32'h0);
        chk("reset_wordd",  wordd | 32'(validd) | 32'(filld), 32'h0);

        // Table: full word collection from fixed raw patterns.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            collect(vecs[v].pat, 99, edges);
            chk($sformatf("v%0d_latency", v), 32'(edges), 32'(vecs[v].exp_edges));
            chk($sformatf("v%0d_word0", v),   word0, vecs[v].exp_word);
            chk($sformatf("v%0d_valid0", v),  32'(valid0), 32'h1);
            chk($sformatf("v%0d_fill0", v),   32'(fill0), 32'h0);
            chk($sformatf("v%0d_hf0", v),     32'(hf0), 32'h0);
            chk($sformatf("v%0d_wordw", v),   wordw, vecs[v].exp_word ^ lfsr_n(32));
            chk($sformatf("v%0d_validw", v),  32'(validw), 32'h1);
        end

        // Word held while ack stays low, then consumed and collection restarts.
        do_reset();
        collect(4'b0101, 99, edges);
        chk("hold_ready", 32'(valid0), 32'h1);
        saved_w   = wordw;
        w_changed = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (wordw !== saved_w || fill0 !== 6'd0 || valid0 !== 1'b1) w_changed = 1'b1;
        end
        chk("hold_stable", 32'(w_changed), 32'h0);
        chk("hold_wordw", wordw, 32'hAAAA_AAAA ^ 32'hAAAA_AAAA ^ (32'h0 ^ lfsr_n(32)));
        ack = 1'b1; raw_bit = ~raw_bit;
        @(negedge clk);
        chk("ack_valid0", 32'(valid0), 32'h0);
        chk("ack_wordw",  wordw, 32'h0);
        chk("ack_validw", 32'(validw), 32'h0);
        raw_bit = ~raw_bit;
        @(negedge clk);
        chk("restart_fill_a", 32'(fill0), 32'h0);
        raw_bit = ~raw_bit;
        @(negedge clk);
        chk("restart_fill_b", 32'(fill0), 32'h1);
        ack = 1'b0;

        // Enable dropped mid-word; the next word needs 32 fresh bits, LFSR keeps running.
        do_reset();
        collect(4'b1010, 17, edges);
        chk("drop_latency", 32'(edges), 32'd35);
        chk("drop_fill17", 32'(fill0), 32'd17);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_fill0", 32'(fill0), 32'h0);
        chk("drop_fillw", 32'(fillw), 32'h0);
        collect(4'b1010, 99, edges);
        chk("reen_latency", 32'(edges), 32'd65);
        chk("reen_word0",   word0, 32'hFFFF_FFFF);
        chk("reen_wordw",   wordw, 32'hFFFF_FFFF ^ lfsr_n(49));
        // Async reset with a word pending clears everything without a clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("areset_word0",  word0, 32'h0);
        chk("areset_wordw",  wordw, 32'h0);
        chk("areset_valid0", 32'(valid0), 32'h0);
        chk("areset_validw", 32'(validw), 32'h0);

        // Reset mid-word, then LFSR must restart from the seed.
        do_reset();
        collect(4'b1010, 5, edges);
        chk("mid_fill5", 32'(fill0), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_fill0", 32'(fill0), 32'h0);
        chk("mid_reset_fillw", 32'(fillw), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b0;
        @(negedge clk);
        collect(4'b1010, 99, edges);
        chk("seed_latency", 32'(edges), 32'd65);
        chk("seed_wordw",   wordw, 32'hFFFF_FFFF ^ lfsr_n(32));

        // Stuck-at-1 source trips the repetition test.
        do_reset();
        raw_bit = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        e0 = 0; ed = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (hf0 && e0 == 0) e0 = e;
            if (hfd && ed == 0) ed = e;
        end
        chk("fault_edge_div1", 32'(e0), 32'd17);
        chk("fault_edge_div3", 32'(ed), 32'd49);
        chk("fault_hfw",    32'(hfw), 32'h1);
        chk("fault_valid0", 32'(valid0), 32'h0);
        for (int t = 0; t < 6; t++) begin
            ack    = t[0];
            enable = t[1];
            raw_bit = t[0];
            @(negedge clk);
        end
        chk("fault_sticky0", 32'(hf0), 32'h1);
        chk("fault_stickyd", 32'(hfd), 32'h1);
        chk("fault_word0",   word0, 32'h0);
        chk("fault_fill0",   32'(fill0), 32'h0);
        do_reset();
        chk("fault_cleared0", 32'(hf0), 32'h0);
        chk("fault_clearedd", 32'(hfd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
